// File: rtl/me_pkg.sv
// Shared constants and state type for the motion-estimation block loader.
package me_pkg;

  localparam int PIX_W        = 8;
  localparam int CUR_WORDS    = 32;
  localparam int REF_WORDS    = 128;
  localparam int PIX_PER_WORD = 8;
  localparam int CUR_AW       = $clog2(CUR_WORDS);
  localparam int REF_AW       = $clog2(REF_WORDS);

  typedef enum logic [1:0] {
    LOAD_CUR  = 2'd0,
    LOAD_REF  = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/me_pix_packer.sv
// Packs accepted pixels into 64-bit words, first pixel in the low byte;
// word_valid pulses for one cycle after the eighth pixel of a word.
module me_pix_packer
  import me_pkg::*;
#(
  parameter int PIX_W = me_pkg::PIX_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pix_accept,
  input  logic [PIX_W-1:0]              pix_data,
  output logic [PIX_PER_WORD*PIX_W-1:0] word_next,
  output logic                          word_last,
  output logic                          word_valid
);

  localparam int WORD_W = PIX_PER_WORD * PIX_W;

  logic [WORD_W-1:0] shift_q;
  logic [2:0]        byte_cnt_q;

  // New pixels enter at the top, so after eight shifts the oldest sits in the low byte.
  assign word_next = {pix_data, shift_q[WORD_W-1:PIX_W]};
  assign word_last = pix_accept && (byte_cnt_q == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= word_last;
      if (pix_accept) begin
        shift_q    <= word_next;
        byte_cnt_q <= byte_cnt_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/me_block_loader.sv
// Streams a 16x16 current block then a 32x32 reference window into word
// memories, then starts the motion-estimation engine and waits for done.
module me_block_loader
  import me_pkg::*;
#(
  parameter int PIX_W     = me_pkg::PIX_W,
  parameter int CUR_WORDS = me_pkg::CUR_WORDS,
  parameter int REF_WORDS = me_pkg::REF_WORDS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pix_valid,
  input  logic [PIX_W-1:0]              pix_data,
  output logic                          pix_ready,
  output logic [CUR_AW-1:0]             address_write_cur,
  output logic [PIX_PER_WORD*PIX_W-1:0] data_write_cur,
  output logic                          write_enable_cur,
  output logic [REF_AW-1:0]             address_write_ref,
  output logic [PIX_PER_WORD*PIX_W-1:0] data_write_ref,
  output logic                          write_enable_ref,
  output logic                          go,
  input  logic                          done,
  output logic                          busy,
  output state_t                        dbg_state
);

  localparam int WORD_W = PIX_PER_WORD * PIX_W;
  localparam int SH     = $clog2(PIX_PER_WORD);
  localparam int CNT_W  = $clog2(REF_WORDS * PIX_PER_WORD);
  localparam logic [CNT_W-1:0] CUR_LAST = CNT_W'(CUR_WORDS * PIX_PER_WORD - 1);
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REF_WORDS * PIX_PER_WORD - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  pix_cnt_q;
  logic              ready_q, go_q, word_is_cur_q;
  logic              accept, word_last, word_valid;
  logic [WORD_W-1:0] word_next;

  // A pixel transfers on a rising clk where pix_valid and pix_ready are both high;
  // pix_ready never depends on pix_valid.
  assign accept    = pix_valid && pix_ready;
  assign pix_ready = ready_q && !reset;
  assign go        = go_q && !reset;
  assign busy      = !reset && !(state_q == LOAD_CUR && pix_cnt_q == '0);
  assign dbg_state = state_q;

  assign write_enable_cur = word_valid && word_is_cur_q && !reset;
  assign write_enable_ref = word_valid && !word_is_cur_q && !reset;

  me_pix_packer #(.PIX_W(PIX_W)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .pix_accept(accept),
    .pix_data  (pix_data),
    .word_next (word_next),
    .word_last (word_last),
    .word_valid(word_valid)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_CUR:  if (accept && pix_cnt_q == CUR_LAST) state_d = LOAD_REF;
      LOAD_REF:  if (accept && pix_cnt_q == REF_LAST) state_d = WAIT_DONE;
      WAIT_DONE: if (done) state_d = LOAD_CUR;
      default:   state_d = LOAD_CUR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= LOAD_CUR;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt_q         <= '0;
      ready_q           <= 1'b0;
      go_q              <= 1'b0;
      word_is_cur_q     <= 1'b0;
      address_write_cur <= '0;
      data_write_cur    <= '0;
      address_write_ref <= '0;
      data_write_ref    <= '0;
    end else begin
      ready_q <= (state_d != WAIT_DONE);
      // Pixel count restarts at each phase boundary so it doubles as the word address.
      if (accept)
        pix_cnt_q <= (state_d != state_q) ? '0 : pix_cnt_q + CNT_W'(1);
      else if (state_q == WAIT_DONE)
        pix_cnt_q <= '0;
      if (state_q == LOAD_REF && state_d == WAIT_DONE)
        go_q <= 1'b1;
      else if (state_q == WAIT_DONE && state_d == LOAD_CUR)
        go_q <= 1'b0;
      if (word_last) begin
        if (state_q == LOAD_CUR) begin
          word_is_cur_q     <= 1'b1;
          address_write_cur <= pix_cnt_q[SH +: CUR_AW];
          data_write_cur    <= word_next;
        end else begin
          word_is_cur_q     <= 1'b0;
          address_write_ref <= pix_cnt_q[SH +: REF_AW];
          data_write_ref    <= word_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_me_block_loader.sv
// Self-checking bench for me_block_loader: pixel-count model checked every cycle
// plus literal expectations on packed words, write counts and handshake timing.
module tb_me_block_loader;
  import me_pkg::*;

  logic        clk = 1'b0;
  logic        reset, pix_valid, done;
  logic [7:0]  pix_data;
  logic        pix_ready, write_enable_cur, write_enable_ref, go, busy;
  logic [4:0]  address_write_cur;
  logic [6:0]  address_write_ref;
  logic [63:0] data_write_cur, data_write_ref;
  state_t      dbg_state;

  me_block_loader dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready),
    .address_write_cur(address_write_cur), .data_write_cur(data_write_cur),
    .write_enable_cur(write_enable_cur),
    .address_write_ref(address_write_ref), .data_write_ref(data_write_ref),
    .write_enable_ref(write_enable_ref),
    .go(go), .done(done), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: pixels accepted in the block decide everything.
  logic       chk_en = 1'b0;
  logic       m_ready, m_go, m_we_cur, m_we_ref, m_wait;
  logic [4:0] m_addr_cur;
  logic [6:0] m_addr_ref;
  logic [63:0] m_data_cur, m_data_ref, m_word;
  int         m_n;
  logic [7:0] m_buf[$];

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_ready = 0; m_go = 0; m_we_cur = 0; m_we_ref = 0; m_wait = 0; m_n = 0;
      m_addr_cur = 0; m_addr_ref = 0; m_data_cur = 0; m_data_ref = 0;
      m_buf.delete();
      chk_en = 1'b1;
    end else begin
      m_we_cur = 0;
      m_we_ref = 0;
      if (m_wait) begin
        if (done) begin m_wait = 0; m_go = 0; m_n = 0; end
      end else if (pix_valid && m_ready) begin
        m_buf.push_back(pix_data);
        if (m_buf.size() == 8) begin
          m_word = '0;
          for (int b = 0; b < 8; b++) m_word[b*8 +: 8] = m_buf[b];
          m_buf.delete();
          if (m_n < 256) begin
            m_we_cur = 1; m_addr_cur = 5'(m_n / 8); m_data_cur = m_word;
          end else begin
            m_we_ref = 1; m_addr_ref = 7'((m_n - 256) / 8); m_data_ref = m_word;
          end
        end
        m_n++;
        if (m_n == 1280) begin m_wait = 1; m_go = 1; end
      end
      m_ready = !m_wait;
    end
  end

  // Write monitor state for literal checks.
  logic [63:0] cur_mem[32];
  logic [63:0] ref_mem[128];
  int          n_cur_w, n_ref_w;
  int          cur0_cyc[$];
  int          done_cyc[$];
  logic [4:0]  first_cur_addr;
  logic [63:0] first_cur_data;

  always @(negedge clk) begin
    if (chk_en) begin
      state_t exp_state;
      exp_state = m_wait ? WAIT_DONE : (m_n < 256 ? LOAD_CUR : LOAD_REF);
      check("pix_ready",   64'(pix_ready),         64'(m_ready && !reset));
      check("go",          64'(go),                64'(m_go && !reset));
      check("busy",        64'(busy),              64'(!reset && (m_wait || m_n != 0)));
      check("we_cur",      64'(write_enable_cur),  64'(m_we_cur && !reset));
      check("we_ref",      64'(write_enable_ref),  64'(m_we_ref && !reset));
      check("addr_cur",    64'(address_write_cur), 64'(m_addr_cur));
      check("data_cur",    data_write_cur,         m_data_cur);
      check("addr_ref",    64'(address_write_ref), 64'(m_addr_ref));
      check("data_ref",    data_write_ref,         m_data_ref);
      check("state",       64'(dbg_state),         64'(exp_state));
      if (write_enable_cur) begin
        if (n_cur_w == 0) begin
          first_cur_addr = address_write_cur;
          first_cur_data = data_write_cur;
        end
        cur_mem[address_write_cur] = data_write_cur;
        n_cur_w++;
        if (address_write_cur == 5'd0) cur0_cyc.push_back(cyc);
      end
      if (write_enable_ref) begin
        ref_mem[address_write_ref] = data_write_ref;
        n_ref_w++;
        if (address_write_ref == 7'd127) check("go_with_ref127", 64'(go), 64'(1));
      end
    end
  end

  task automatic clear_stats();
    n_cur_w = 0;
    n_ref_w = 0;
    cur0_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic do_reset(input int n);
    reset = 1; pix_valid = 0; done = 0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    check("rst_ready",    64'(pix_ready),         64'(0));
    check("rst_go",       64'(go),                64'(0));
    check("rst_busy",     64'(busy),              64'(0));
    check("rst_we",       64'({write_enable_cur, write_enable_ref}), 64'(0));
    check("rst_addr_cur", 64'(address_write_cur), 64'(0));
    check("rst_data_cur", data_write_cur,         64'(0));
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("post_rst_ready_low", 64'(pix_ready), 64'(0));
    @(negedge clk);
    check("post_rst_ready_high", 64'(pix_ready), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic send_stream(input int n, input bit gap, input int pulse_at);
    bit got;
    for (int k = 0; k < n; k++) begin
      if (k == pulse_at) begin
        pix_valid = 0;
        done = 1;
        @(negedge clk);
        check("go_during_ref_done", 64'(go), 64'(0));
        @(posedge clk);
        #1 done = 0;
      end
      pix_valid = 1;
      pix_data  = 8'(k);
      got = 0;
      for (int t = 0; t < 2000; t++) begin
        @(negedge clk);
        if (pix_ready) begin got = 1; break; end
      end
      if (!got) begin
        n_vec++; n_err++;
        $display("FAIL ready_timeout at pixel %0d: got pix_ready 0 expected 1", k);
        pix_valid = 0;
        return;
      end
      @(posedge clk);
      #1;
      if (gap) begin
        pix_valid = 0;
        @(posedge clk);
        #1;
      end
    end
    pix_valid = 0;
  endtask

  task automatic respond_done(input int blocks);
    bit got;
    for (int b = 0; b < blocks; b++) begin
      got = 0;
      for (int t = 0; t < 6000; t++) begin
        @(negedge clk);
        if (go) begin got = 1; break; end
      end
      if (!got) begin
        n_vec++; n_err++;
        $display("FAIL go_timeout in block %0d: got go 0 expected 1", b);
        return;
      end
      check("ready_in_wait", 64'(pix_ready), 64'(0));
      repeat (5) @(posedge clk);
      #1 done = 1;
      @(posedge clk);
      #1 done = 0;
      done_cyc.push_back(cyc);
      @(negedge clk);
      check("go_drop", 64'(go), 64'(0));
      check("ready_after_done", 64'(pix_ready), 64'(1));
    end
  endtask

  task automatic check_block(input string tag, input int blocks);
    check({tag, "_n_cur"},   64'(n_cur_w), 64'(32 * blocks));
    check({tag, "_n_ref"},   64'(n_ref_w), 64'(128 * blocks));
    check({tag, "_cur0"},    cur_mem[0],   64'h0706050403020100);
    check({tag, "_cur31"},   cur_mem[31],  64'hFFFEFDFCFBFAF9F8);
    check({tag, "_ref0"},    ref_mem[0],   64'h0706050403020100);
    check({tag, "_ref127"},  ref_mem[127], 64'hFFFEFDFCFBFAF9F8);
  endtask

  initial begin
    reset = 1; pix_valid = 0; pix_data = 0; done = 0;
    n_cur_w = 0; n_ref_w = 0;
    do_reset(3);

    // Continuous stream
    clear_stats();
    fork
      send_stream(1280, 1'b0, -1);
      respond_done(1);
    join
    repeat (3) @(posedge clk);
    #1;
    check_block("cont", 1);

    // pix_valid every other cycle
    clear_stats();
    fork
      send_stream(1280, 1'b1, -1);
      respond_done(1);
    join
    repeat (3) @(posedge clk);
    #1;
    check_block("gap", 1);

    // done pulsed while loading the reference window
    clear_stats();
    fork
      send_stream(1280, 1'b0, 256 + 40);
      respond_done(1);
    join
    repeat (3) @(posedge clk);
    #1;
    check_block("stray_done", 1);

    // Reset after 100 current-block pixels
    send_stream(100, 1'b0, -1);
    repeat (2) @(posedge clk);
    #1;
    do_reset(2);
    clear_stats();
    fork
      send_stream(1280, 1'b0, -1);
      respond_done(1);
    join
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_first_addr", 64'(first_cur_addr), 64'(0));
    check("post_reset_first_data", first_cur_data, 64'h0706050403020100);
    check_block("after_rst", 1);

    // Back-to-back blocks
    clear_stats();
    fork
      send_stream(2560, 1'b0, -1);
      respond_done(2);
    join
    repeat (3) @(posedge clk);
    #1;
    check_block("b2b", 2);
    check("b2b_cur0_count", 64'(cur0_cyc.size()), 64'(2));
    if (cur0_cyc.size() == 2 && done_cyc.size() == 2)
      check("b2b_order", 64'(cur0_cyc[1] > done_cyc[0]), 64'(1));
    else begin
      n_vec++; n_err++;
      $display("FAIL b2b_events: got %0d cur0 writes and %0d dones expected 2 and 2",
               cur0_cyc.size(), done_cyc.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/me_block_loader.md
ME_BLOCK_LOADER -- requirements
Module: me_block_loader

Interface
REQ-001 SHALL have parameter PIX_W, default 8, bits per pixel.
REQ-002 SHALL have parameter CUR_WORDS, default 32, 64-bit words per 16x16 current block.
REQ-003 SHALL have parameter REF_WORDS, default 128, 64-bit words per 32x32 reference window.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port pix_valid  input  1  upstream pixel valid.
REQ-007 SHALL have port pix_data  input  8  pixel, raster order.
REQ-008 SHALL have port pix_ready  output  1  loader accepts pixel this cycle.
REQ-009 SHALL have port address_write_cur  output  5  current-block word address.
REQ-010 SHALL have port data_write_cur  output  64  packed current-block word.
REQ-011 SHALL have port write_enable_cur  output  1  current-block write strobe.
REQ-012 SHALL have port address_write_ref  output  7  reference-window word address.
REQ-013 SHALL have port data_write_ref  output  64  packed reference word.
REQ-014 SHALL have port write_enable_ref  output  1  reference write strobe.
REQ-015 SHALL have port go  output  1  start request to motion-estimation engine.
REQ-016 SHALL have port done  input  1  engine finished current search.
REQ-017 SHALL have port busy  output  1  high whenever state is not LOAD_CUR with zero pixels accepted.

Function
REQ-018 SHALL implement states LOAD_CUR, LOAD_REF, WAIT_DONE.
REQ-019 SHALL assert pix_ready in LOAD_CUR and LOAD_REF only; transfer occurs when pix_valid and pix_ready are both high.
REQ-020 SHALL pack 8 accepted pixels per word, first pixel in bits [7:0], eighth in bits [63:56]; pix_valid gaps SHALL not disturb packing.
REQ-021 SHALL present a word with its write_enable high for exactly one cycle, the cycle after the 8th pixel is accepted (latency 1).
REQ-022 SHALL use address = word index in arrival order (cur: 0..31 = row*2+col/8; ref: 0..127 = row*4+col/8).
REQ-023 SHALL move LOAD_CUR -> LOAD_REF on acceptance of pixel 256, and LOAD_REF -> WAIT_DONE on acceptance of pixel 1024 of the reference.
REQ-024 SHALL raise go in the cycle the last reference word is written and hold it high until done is sampled high.
REQ-025 SHALL, on done sampled high in WAIT_DONE, drop go next cycle, clear counters and return to LOAD_CUR; done outside WAIT_DONE SHALL be ignored.
REQ-026 SHALL never assert write_enable_cur and write_enable_ref in the same cycle.
REQ-027 SHALL hold address/data outputs stable when write enables are low.

Reset
REQ-028 SHALL on reset drive pix_ready=0, go=0, both write enables=0, addresses=0, data=0, busy=0, state=LOAD_CUR, counters=0; pix_ready rises the cycle after reset falls.
REQ-029 SHALL, on reset mid-load or mid-WAIT_DONE, discard partial words and restart at cur address 0 with no spurious write.

Structure
REQ-030 SHALL take PIX_W, CUR_WORDS, REF_WORDS, address widths and the state enum from shared package me_pkg.
REQ-031 SHALL instantiate one sub-module me_pix_packer (8-to-64 shift packer with 3-bit byte counter and word_valid pulse).

Verification
REQ-032 SHALL cover continuous stream pixel i = i mod 256: cur word 0 = 0x0706050403020100 at addr 0, word 31 = 0xFFFEFDFCFBFAF9F8 at addr 31.
REQ-033 SHALL cover pix_valid toggled every other cycle: identical words/addresses as continuous case, 1280 pixels -> 32 cur + 128 ref writes.
REQ-034 SHALL cover end of load: go rises same cycle as ref addr 127 write; pix_ready=0 until done; done held 5 cycles later -> go=0 next cycle, pix_ready=1.
REQ-035 SHALL cover done pulsed during LOAD_REF: no effect, go stays 0, load completes normally.
REQ-036 SHALL cover reset after 100 cur pixels: no writes during reset, next 8 pixels land at cur addr 0.
REQ-037 SHALL cover back-to-back blocks: second block's cur addr 0 write occurs only after done of first.
